// File: rtl/munoc_wdata_downsizer.sv
// MUNOC slave-side W-channel downsizer: splits master-width write beats
// into slave-width beats with lane-selected data/strobes and generated WLAST.
module munoc_wdata_downsizer #(
    parameter int BW_MASTER_DATA = 128,
    parameter int BW_SLAVE_DATA  = 32,
    parameter int BW_LEN         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [2:0]                           cmd_size,
    input  logic [$clog2(BW_MASTER_DATA/8)-1:0]  cmd_offset,
    input  logic [BW_LEN-1:0]                    cmd_len,
    input  logic                                 m_wvalid,
    output logic                                 m_wready,
    input  logic [BW_MASTER_DATA-1:0]            m_wdata,
    input  logic [BW_MASTER_DATA/8-1:0]          m_wstrb,
    input  logic                                 m_wlast,
    output logic                                 s_wvalid,
    input  logic                                 s_wready,
    output logic [BW_SLAVE_DATA-1:0]             s_wdata,
    output logic [BW_SLAVE_DATA/8-1:0]           s_wstrb,
    output logic                                 s_wlast,
    output logic                                 err_last,
    output logic                                 err_size
);

    localparam int MB = BW_MASTER_DATA / 8;
    localparam int SB = BW_SLAVE_DATA / 8;
    localparam int SS = $clog2(SB);
    localparam int MS = $clog2(MB);
    localparam int R  = MB / SB;
    localparam int LW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [2:0]        size_q;
    logic [MS-1:0]     offset_q;
    logic [BW_LEN-1:0] len_q;
    logic [BW_LEN-1:0] beat_cnt;
    logic [LW-1:0]     sub_cnt;

    logic          active;
    logic          wide;
    logic          last_sub;
    logic          beat_last;
    logic          s_fire;
    logic          cmd_fire;
    logic [LW-1:0] sub_max;
    logic [MS-1:0] lane_w;
    logic [LW-1:0] lane;
    logic [2:0]    size_c;
    logic [MS-1:0] align_mask;
    logic [MS-1:0] step;

    always_comb begin
        active     = (state == ACTIVE) && !rst;
        wide       = size_q > 3'(SS);
        sub_max    = LW'((32'd1 << (size_q - 3'(SS))) - 32'd1);
        last_sub   = !wide || (sub_cnt == sub_max);
        beat_last  = (beat_cnt == len_q);
        // sub_cnt is zero in narrow mode, so one sum covers both modes
        lane_w     = MS'(offset_q >> SS) + MS'(sub_cnt);
        lane       = lane_w[LW-1:0];
        size_c     = (cmd_size > 3'(MS)) ? 3'(MS) : cmd_size;
        align_mask = MS'((32'd1 << size_c) - 32'd1);
        step       = MS'(32'd1 << size_q);

        cmd_ready  = (state == IDLE) && !rst;
        cmd_fire   = cmd_ready && cmd_valid;
        s_wvalid   = active && m_wvalid;
        m_wready   = active && s_wready && last_sub;
        s_wlast    = active && beat_last && last_sub;
        s_fire     = s_wvalid && s_wready;
        s_wdata    = m_wdata[int'(lane)*BW_SLAVE_DATA +: BW_SLAVE_DATA];
        s_wstrb    = m_wstrb[int'(lane)*SB +: SB];
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:   if (cmd_fire) state_d = ACTIVE;
            ACTIVE: if (s_fire && s_wlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            size_q   <= '0;
            offset_q <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            sub_cnt  <= '0;
            err_last <= 1'b0;
            err_size <= 1'b0;
        end else begin
            state <= state_d;
            if (cmd_fire) begin
                size_q   <= size_c;
                offset_q <= cmd_offset & ~align_mask;
                len_q    <= cmd_len;
                beat_cnt <= '0;
                sub_cnt  <= '0;
                if (cmd_size > 3'(MS)) err_size <= 1'b1;
            end
            if (s_fire) begin
                if (last_sub) begin
                    // master beat consumed: advance address, wrap mod MB
                    sub_cnt  <= '0;
                    offset_q <= offset_q + step;
                    beat_cnt <= beat_cnt + 1'b1;
                    if (m_wlast != beat_last) err_last <= 1'b1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_munoc_wdata_downsizer.sv
// Scoreboard bench for munoc_wdata_downsizer (128 -> 32) with a
// byte-address reference model and randomized backpressure.
module tb_munoc_wdata_downsizer;

    logic         clk = 0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_size;
    logic [3:0]   cmd_offset;
    logic [7:0]   cmd_len;
    logic         m_wvalid;
    logic         m_wready;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic         m_wlast;
    logic         s_wvalid;
    logic         s_wready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wlast;
    logic         err_last;
    logic         err_size;

    munoc_wdata_downsizer #(
        .BW_MASTER_DATA(128),
        .BW_SLAVE_DATA (32),
        .BW_LEN        (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_size  (cmd_size),
        .cmd_offset(cmd_offset),
        .cmd_len   (cmd_len),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .err_last  (err_last),
        .err_size  (err_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        mrdy;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   fires   = 0;
    bit   bp_mode = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // slave-side ready, optionally randomized
    initial begin
        s_wready = 1;
        forever begin
            @(posedge clk);
            #1 s_wready = bp_mode ? 1'($urandom % 2) : 1'b1;
        end
    end

    // monitor: a beat fires at the next posedge when valid&ready at negedge
    initial begin
        bit          stall = 0;
        logic [31:0] pd;
        logic [3:0]  ps;
        logic        pl;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else if (s_wvalid) begin
                if (stall) begin
                    chk("stall_data", s_wdata, pd);
                    chk("stall_strb", s_wstrb, ps);
                    chk("stall_last", s_wlast, pl);
                end
                if (s_wready) begin
                    fires++;
                    stall = 0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("s_wdata", s_wdata, e.data);
                        chk("s_wstrb", s_wstrb, e.strb);
                        chk("s_wlast", s_wlast, e.last);
                        chk("m_wready", m_wready, e.mrdy);
                    end
                end else begin
                    stall = 1;
                    pd = s_wdata;
                    ps = s_wstrb;
                    pl = s_wlast;
                end
            end else begin
                stall = 0;
            end
        end
    end

    task automatic send_cmd(int size, int off, int len);
        bit ok = 0;
        cmd_valid  = 1;
        cmd_size   = 3'(size);
        cmd_offset = 4'(off);
        cmd_len    = 8'(len);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("cmd_timeout", 0, 1);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic send_beat(logic [127:0] d, logic [15:0] s, logic l);
        bit ok = 0;
        m_wvalid = 1;
        m_wdata  = d;
        m_wstrb  = s;
        m_wlast  = l;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (m_wready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("beat_timeout", 0, 1);
        @(posedge clk);
        #1 m_wvalid = 0;
    endtask

    // reference: byte address walks by 2^size modulo 16, slave lane =
    // byte address / 4; a wide beat spans consecutive 4-byte chunks
    task automatic push_beat(logic [127:0] d, logic [15:0] s,
                             int sz, int addr, bit final_beat);
        int   nsub;
        int   lane;
        exp_t e;
        nsub = (sz > 2) ? (1 << (sz - 2)) : 1;
        for (int k = 0; k < nsub; k++) begin
            lane   = ((addr + 4 * k) % 16) / 4;
            e.data = 32'(d >> (32 * lane));
            e.strb = 4'(s >> (4 * lane));
            e.last = final_beat && (k == nsub - 1);
            e.mrdy = (k == nsub - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic run_burst(int csize, int off, int len,
                             int bad_last, int fix_strb, bit gaps);
        int           sz;
        int           addr;
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
        sz   = (csize > 4) ? 4 : csize;
        addr = off & ~((1 << sz) - 1) & 15;
        send_cmd(csize, off, len);
        for (int b = 0; b <= len; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            s = (fix_strb >= 0) ? 16'(fix_strb) : 16'($urandom);
            l = (bad_last >= 0) ? (b == bad_last) : (b == len);
            push_beat(d, s, sz, addr, b == len);
            addr = (addr + (1 << sz)) % 16;
            if (gaps && ($urandom % 3 == 0)) begin
                @(posedge clk);
                #1;
            end
            send_beat(d, s, l);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int f0;
        rst       = 1;
        cmd_valid = 0;
        cmd_size  = 0;
        cmd_offset = 0;
        cmd_len   = 0;
        m_wvalid  = 1;
        m_wdata   = '1;
        m_wstrb   = '1;
        m_wlast   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_s_wvalid", s_wvalid, 0);
        chk("rst_m_wready", m_wready, 0);
        chk("rst_s_wlast", s_wlast, 0);
        rst = 0;
        #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_m_wready", m_wready, 0);
        chk("idle_s_wvalid", s_wvalid, 0);
        chk("rst_err_last", err_last, 0);
        chk("rst_err_size", err_size, 0);
        @(posedge clk);
        #1 m_wvalid = 0;

        run_burst(2, 8, 3, -1, -1, 0);
        chk("t1_err_last", err_last, 0);
        run_burst(4, 0, 1, -1, -1, 0);
        run_burst(3, 8, 0, -1, 16'hFF00, 0);
        chk("t3_cmd_ready_after", cmd_ready, 1);
        bp_mode = 1;
        run_burst(4, 0, 7, -1, -1, 0);
        bp_mode = 0;
        chk("t4_sb_empty", sb_q.size(), 0);
        chk("t4_err_size", err_size, 0);

        run_burst(2, 0, 3, 1, -1, 0);
        chk("t5_err_last", err_last, 1);
        run_burst(5, 4, 1, -1, -1, 0);
        chk("t5_err_size", err_size, 1);

        // reset in the middle of a wide burst
        send_cmd(4, 0, 3);
        f0 = fires;
        m_wvalid = 1;
        m_wdata  = {$urandom, $urandom, $urandom, $urandom};
        m_wstrb  = 16'hFFFF;
        m_wlast  = 0;
        push_beat(m_wdata, m_wstrb, 4, 0, 0);
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (fires - f0 >= 3) break;
        end
        chk("t6_three_fires", fires - f0, 3);
        #1 rst = 1;
        m_wvalid = 0;
        @(posedge clk);
        #1;
        sb_q.delete();
        chk("t6_rst_s_wvalid", s_wvalid, 0);
        rst = 0;
        #1;
        chk("t6_idle", cmd_ready, 1);
        chk("t6_err_last_clr", err_last, 0);
        chk("t6_err_size_clr", err_size, 0);
        run_burst(4, 0, 1, -1, -1, 0);
        chk("t6_sb_empty", sb_q.size(), 0);

        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            run_burst(int'($urandom % 5), int'($urandom % 16),
                      int'($urandom % 8), -1, -1, 1);
        end
        bp_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", sb_q.size(), 0);
        chk("final_err_last", err_last, 0);
        chk("final_err_size", err_size, 0);
        chk("final_cmd_ready", cmd_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
